// File: rtl/mem_result_streamer_pkg.sv
// Shared types and defaults for the result-memory dump path.
// The default sizes are also used by the result memory and the compute circuit.
package mem_result_streamer_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DEPTH  = 128;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    CAPT = 3'd2,
    SEND = 3'd3,
    FIN  = 3'd4
  } state_e;

  function automatic int unsigned bytes_per_word(input int unsigned w);
    return w / 32'd8;
  endfunction

  localparam int BYTES_PER_WORD = bytes_per_word(DEF_DATA_W);

endpackage

// File: rtl/mem_result_streamer_if.sv
// Memory read port plus byte stream between the streamer and its neighbours.
// The master side is the streamer; the slave side is memory plus host.
interface mem_result_streamer_if
  import mem_result_streamer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic [ADDR_W-1:0] mem_index;
  logic [DATA_W-1:0] mem_data;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output mem_index,
    input  mem_data,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  mem_index,
    output mem_data,
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/mem_result_streamer_word_serializer.sv
// Splits one loaded word into bytes, least significant byte first, on a valid/ready stream.
// data/valid hold steady while the consumer stalls.
module word_serializer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic [7:0]        data,
  output logic              valid,
  output logic              last_byte
);

  localparam int NBYTES = DATA_W / 8;
  localparam int BC_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BC_W-1:0] LAST_CNT = BC_W'(NBYTES - 1);

  logic [DATA_W-1:0] shift_r;
  logic [DATA_W-1:0] shifted_s;
  logic [BC_W-1:0]   cnt_r;
  logic [7:0]        data_r;
  logic              valid_r;

  assign shifted_s = shift_r >> 4'd8;
  assign last_byte = (cnt_r == LAST_CNT);
  assign data      = data_r;
  assign valid     = valid_r;

  // Shift register, byte counter and registered stream outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_r <= {DATA_W{1'b0}};
      cnt_r   <= {BC_W{1'b0}};
      data_r  <= 8'd0;
      valid_r <= 1'b0;
    end else if (load) begin
      shift_r <= load_data;
      cnt_r   <= {BC_W{1'b0}};
      data_r  <= load_data[7:0];
      valid_r <= 1'b1;
    end else if (valid_r && ready) begin
      if (last_byte) begin
        cnt_r   <= {BC_W{1'b0}};
        valid_r <= 1'b0;
      end else begin
        shift_r <= shifted_s;
        data_r  <= shifted_s[7:0];
        cnt_r   <= cnt_r + BC_W'(1);
        valid_r <= 1'b1;
      end
    end else begin
      shift_r <= shift_r;
      cnt_r   <= cnt_r;
      data_r  <= data_r;
      valid_r <= valid_r;
    end
  end

endmodule

// File: rtl/mem_result_streamer.sv
// Dumps result memory words 0..DEPTH-1 as a byte stream when start rises,
// accumulating a wrapping additive checksum of the dumped words.
module mem_result_streamer
  import mem_result_streamer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  mem_result_streamer_if.master    bus,
  output logic                     busy,
  output logic                     finished,
  output logic [DATA_W-1:0]        checksum
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_e            state_r;
  state_e            state_n_s;
  logic              start_q_r;
  logic [ADDR_W-1:0] mem_index_r;
  logic [DATA_W-1:0] checksum_r;
  logic              busy_r;
  logic              finished_r;

  logic trigger_s;
  logic clear_s;
  logic load_s;
  logic word_inc_s;
  logic enter_fin_s;
  logic accept_s;
  logic last_byte_s;
  logic ser_valid_s;
  logic [7:0] ser_data_s;

  assign trigger_s     = start && !start_q_r;
  assign accept_s      = ser_valid_s && bus.out_ready;
  assign bus.mem_index = mem_index_r;
  assign bus.out_data  = ser_data_s;
  assign bus.out_valid = ser_valid_s;
  assign busy          = busy_r;
  assign finished      = finished_r;
  assign checksum      = checksum_r;

  word_serializer #(.DATA_W(DATA_W)) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .load_data (bus.mem_data),
    .ready     (bus.out_ready),
    .data      (ser_data_s),
    .valid     (ser_valid_s),
    .last_byte (last_byte_s)
  );

  // Next-state and per-cycle control strobes
  always_comb begin
    state_n_s   = state_r;
    clear_s     = 1'b0;
    load_s      = 1'b0;
    word_inc_s  = 1'b0;
    enter_fin_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (trigger_s) begin
          state_n_s = READ;
          clear_s   = 1'b1;
        end else begin
          state_n_s = IDLE;
        end
      end
      READ: state_n_s = CAPT;
      CAPT: begin
        state_n_s = SEND;
        load_s    = 1'b1;
      end
      SEND: begin
        if (accept_s && last_byte_s) begin
          // The index stops at DEPTH-1; the dump ends rather than wrapping.
          if (mem_index_r < LAST_IDX) begin
            state_n_s  = READ;
            word_inc_s = 1'b1;
          end else begin
            state_n_s   = FIN;
            enter_fin_s = 1'b1;
          end
        end else begin
          state_n_s = SEND;
        end
      end
      FIN:     state_n_s = IDLE;
      default: state_n_s = IDLE;
    endcase
  end

  // State, edge history, word index, checksum and status registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      start_q_r   <= 1'b1;
      mem_index_r <= {ADDR_W{1'b0}};
      checksum_r  <= {DATA_W{1'b0}};
      busy_r      <= 1'b0;
      finished_r  <= 1'b0;
    end else begin
      state_r    <= state_n_s;
      start_q_r  <= start;
      finished_r <= enter_fin_s;
      if (clear_s) begin
        mem_index_r <= {ADDR_W{1'b0}};
        checksum_r  <= {DATA_W{1'b0}};
        busy_r      <= 1'b1;
      end else if (word_inc_s) begin
        mem_index_r <= mem_index_r + ADDR_W'(1);
      end else if (load_s) begin
        checksum_r <= checksum_r + bus.mem_data;
      end else if (enter_fin_s) begin
        busy_r <= 1'b0;
      end else begin
        mem_index_r <= mem_index_r;
      end
    end
  end

endmodule

// File: tb/tb_mem_result_streamer.sv
// Directed bench: expected bytes are queued when a dump is triggered and
// popped as the stream hands them over; status values are checked in line.
module tb_mem_result_streamer;
  import mem_result_streamer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic start1 = 1'b0;
  logic busy, finished, busy1, finished1;
  logic [31:0] checksum, checksum1;

  logic [31:0] mem [128];
  logic [31:0] mem1_word = 32'd0;
  logic [7:0]  q[$];
  logic [7:0]  q1[$];
  int n_cmp = 0;
  int n_err = 0;
  int acc_cnt = 0;
  int acc1_cnt = 0;
  int fin_cnt = 0;
  logic        stall_r = 1'b0;
  logic [7:0]  stall_data_r = 8'd0;
  logic        stall1_r = 1'b0;
  logic [7:0]  stall1_data_r = 8'd0;

  mem_result_streamer_if #(.DATA_W(32), .ADDR_W(7)) bus ();
  mem_result_streamer_if #(.DATA_W(32), .ADDR_W(7)) bus1 ();

  mem_result_streamer #(.DATA_W(32), .ADDR_W(7), .DEPTH(128)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .busy(busy), .finished(finished), .checksum(checksum)
  );

  mem_result_streamer #(.DATA_W(32), .ADDR_W(7), .DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .bus(bus1),
    .busy(busy1), .finished(finished1), .checksum(checksum1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.mem_data <= mem[bus.mem_index];
  always @(posedge clk) bus1.mem_data <= mem1_word;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard and stall-stability monitor for the 128-word instance
  always @(negedge clk) begin
    logic [31:0] exp;
    if (rst) begin
      if (stall_r) begin
        check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
        check("stall_data", {24'd0, bus.out_data}, {24'd0, stall_data_r});
      end
      if (bus.out_valid && bus.out_ready) begin
        acc_cnt++;
        if (q.size() > 0) exp = {24'd0, q.pop_front()};
        else exp = 32'hDEAD_BEEF;
        check("byte", {24'd0, bus.out_data}, exp);
      end
      stall_r = bus.out_valid && !bus.out_ready;
      stall_data_r = bus.out_data;
      if (finished) fin_cnt++;
    end else begin
      stall_r = 1'b0;
    end
  end

  // Scoreboard and stall-stability monitor for the single-word instance
  always @(negedge clk) begin
    logic [31:0] exp;
    if (rst) begin
      if (stall1_r) begin
        check("stall1_valid", {31'd0, bus1.out_valid}, 32'd1);
        check("stall1_data", {24'd0, bus1.out_data}, {24'd0, stall1_data_r});
      end
      if (bus1.out_valid && bus1.out_ready) begin
        acc1_cnt++;
        if (q1.size() > 0) exp = {24'd0, q1.pop_front()};
        else exp = 32'hDEAD_BEEF;
        check("byte1", {24'd0, bus1.out_data}, exp);
      end
      stall1_r = bus1.out_valid && !bus1.out_ready;
      stall1_data_r = bus1.out_data;
    end else begin
      stall1_r = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic trigger();
    start = 1'b1;
    for (int i = 0; i < 128; i++)
      for (int b = 0; b < 4; b++) q.push_back(mem[i][8*b +: 8]);
  endtask

  task automatic run_to_fin(input int budget, output int ticks);
    ticks = 0;
    while (finished !== 1'b1 && ticks < budget) begin
      tick();
      ticks++;
    end
    check("finished_seen", {31'd0, finished}, 32'd1);
  endtask

  function automatic logic [31:0] mem_sum();
    logic [31:0] s = 32'd0;
    for (int i = 0; i < 128; i++) s = s + mem[i];
    return s;
  endfunction

  initial begin
    int t;
    int fin_before;
    logic [31:0] exp_sum;
    for (int i = 0; i < 128; i++) mem[i] = i;
    bus.out_ready = 1'b1;
    bus1.out_ready = 1'b1;

    // Reset with start held high
    start = 1'b1;
    repeat (3) tick();
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_finished", {31'd0, finished}, 32'd0);
    check("rst_checksum", checksum, 32'd0);
    check("rst_index", {25'd0, bus.mem_index}, 32'd0);
    check("rst_data", {24'd0, bus.out_data}, 32'd0);
    rst = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      tick();
      check("held_busy", {31'd0, busy}, 32'd0);
      check("held_valid", {31'd0, bus.out_valid}, 32'd0);
    end

    // Dump of word[i]=i with latency and total-length checks
    start = 1'b0;
    tick();
    trigger();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("latency_valid", {31'd0, bus.out_valid}, (k == 2) ? 32'd1 : 32'd0);
    end
    start = 1'b0;
    run_to_fin(1000, t);
    check("dump_cycles", t + 3, 32'd769);
    check("dump_checksum", checksum, 32'h0000_1FC0);
    check("dump_busy_low", {31'd0, busy}, 32'd0);
    check("dump_bytes", acc_cnt, 32'd512);
    check("dump_queue_empty", q.size(), 32'd0);
    tick();
    check("finished_one_cycle", {31'd0, finished}, 32'd0);
    check("finished_pulses", fin_cnt, 32'd1);

    // Single-word instance under a 1,0,0,1 ready pattern
    mem1_word = 32'h1122_3344;
    q1.push_back(8'h44); q1.push_back(8'h33); q1.push_back(8'h22); q1.push_back(8'h11);
    start1 = 1'b1;
    for (int k = 0; k < 80 && finished1 !== 1'b1; k++) begin
      bus1.out_ready = ((k % 4) == 0) || ((k % 4) == 3);
      tick();
    end
    bus1.out_ready = 1'b1;
    check("w1_finished", {31'd0, finished1}, 32'd1);
    check("w1_bytes", acc1_cnt, 32'd4);
    check("w1_queue_empty", q1.size(), 32'd0);
    check("w1_checksum", checksum1, 32'h1122_3344);

    // Consumer stalled for 50 cycles after the first valid
    start = 1'b0;
    tick();
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    exp_sum = mem_sum();
    bus.out_ready = 1'b0;
    trigger();
    for (int k = 0; k < 10 && bus.out_valid !== 1'b1; k++) tick();
    for (int k = 0; k < 50; k++) begin
      check("stall50_valid", {31'd0, bus.out_valid}, 32'd1);
      check("stall50_data", {24'd0, bus.out_data}, {24'd0, mem[0][7:0]});
      check("stall50_index", {25'd0, bus.mem_index}, 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    run_to_fin(1000, t);
    check("stall50_checksum", checksum, exp_sum);
    check("stall50_queue_empty", q.size(), 32'd0);

    // Reset while byte 2 of word 5 is on offer
    start = 1'b0;
    tick();
    for (int i = 0; i < 128; i++) mem[i] = (i * 32'h0101_0101) ^ 32'hA500_0000;
    exp_sum = mem_sum();
    acc_cnt = 0;
    trigger();
    for (int k = 0; k < 500 && acc_cnt < 22; k++) tick();
    check("abort_reached", acc_cnt, 32'd22);
    check("abort_index", {25'd0, bus.mem_index}, 32'd5);
    rst = 1'b0;
    tick();
    check("abort_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_index0", {25'd0, bus.mem_index}, 32'd0);
    check("abort_checksum", checksum, 32'd0);
    q.delete();
    rst = 1'b1;
    repeat (20) tick();
    check("abort_no_bytes", acc_cnt, 32'd22);
    start = 1'b0;
    tick();
    acc_cnt = 0;
    trigger();
    run_to_fin(1000, t);
    check("restart_checksum", checksum, exp_sum);
    check("restart_bytes", acc_cnt, 32'd512);

    // All-ones words with a second start pulse mid-dump
    start = 1'b0;
    tick();
    for (int i = 0; i < 128; i++) mem[i] = 32'hFFFF_FFFF;
    acc_cnt = 0;
    fin_before = fin_cnt;
    trigger();
    repeat (200) tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    run_to_fin(1000, t);
    check("ones_checksum", checksum, 32'hFFFF_FF80);
    repeat (20) tick();
    check("ones_bytes", acc_cnt, 32'd512);
    check("ones_queue_empty", q.size(), 32'd0);
    check("ones_one_finish", fin_cnt - fin_before, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
